// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control unit: Moore FSM driving datapath strobes.
// Optional MEM_WAIT_EN macro stalls FETCH/MEM_READ/MEM_WRITE until memReady_i.
module multi_cycle_control (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       memReady_i,
    output logic [3:0] aluOp_o,
    output logic       pcWrite_o,
    output logic       pcWriteCond_o,
    output logic       iorD_o,
    output logic       memRead_o,
    output logic       memWrite_o,
    output logic       irWrite_o,
    output logic       memToReg_o,
    output logic       regWrite_o,
    output logic       regDst_o,
    output logic       aluSrcA_o,
    output logic [1:0] aluSrcB_o,
    output logic [1:0] pcSource_o,
    output logic [3:0] state_o,
    output logic       illegal_o
);
    localparam int unsigned OPC_W   = 6;
    localparam int unsigned STATE_W = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'b001110;

    localparam logic [OPC_W-1:0] FN_SLL   = 6'b000000;
    localparam logic [OPC_W-1:0] FN_SRL   = 6'b000010;
    localparam logic [OPC_W-1:0] FN_SRLV  = 6'b000110;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    state_t r_state;
    state_t w_state_next;
    state_t w_decode_next;
    logic   r_run;
    logic   w_opcode_legal;
    logic   w_mem_ready;

`ifdef MEM_WAIT_EN
    assign w_mem_ready = memReady_i;
`else
    logic w_unused_mem_ready;
    assign w_unused_mem_ready = memReady_i;
    assign w_mem_ready        = 1'b1;
`endif

    // r_run stays low for the first cycle after reset so FETCH strobes begin on the first edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
        end
    end

    // opcode dispatch out of DECODE
    always_comb begin
        w_decode_next  = S_FETCH;
        w_opcode_legal = 1'b1;
        case (opcode_i)
            OP_LW, OP_SW:                               w_decode_next = S_MEM_ADDR;
            OP_RTYPE:                                   w_decode_next = S_R_EXEC;
            OP_BEQ:                                     w_decode_next = S_BRANCH;
            OP_J:                                       w_decode_next = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: w_decode_next = S_I_EXEC;
            default:                                    w_opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = S_FETCH;
        if (r_run) begin
            case (r_state)
                S_FETCH:     w_state_next = w_mem_ready ? S_DECODE : S_FETCH;
                S_DECODE:    w_state_next = w_decode_next;
                S_MEM_ADDR:  w_state_next = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  w_state_next = w_mem_ready ? S_MEM_WB : S_MEM_READ;
                S_MEM_WRITE: w_state_next = w_mem_ready ? S_FETCH : S_MEM_WRITE;
                S_R_EXEC:    w_state_next = S_R_WB;
                S_I_EXEC:    w_state_next = S_I_WB;
                default:     w_state_next = S_FETCH;
            endcase
        end
    end

    // state decode; all strobes quiet while r_run is low
    always_comb begin
        aluOp_o       = 4'b0000;
        pcWrite_o     = 1'b0;
        pcWriteCond_o = 1'b0;
        iorD_o        = 1'b0;
        memRead_o     = 1'b0;
        memWrite_o    = 1'b0;
        irWrite_o     = 1'b0;
        memToReg_o    = 1'b0;
        regWrite_o    = 1'b0;
        regDst_o      = 1'b0;
        aluSrcA_o     = 1'b0;
        aluSrcB_o     = 2'd0;
        pcSource_o    = 2'd0;
        illegal_o     = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    memRead_o = 1'b1;
                    irWrite_o = w_mem_ready;
                    pcWrite_o = w_mem_ready;
                    aluSrcB_o = 2'd1;
                end
                S_DECODE: begin
                    aluSrcB_o = 2'd3;
                    illegal_o = ~w_opcode_legal;
                end
                S_MEM_ADDR: begin
                    aluSrcA_o = 1'b1;
                    aluSrcB_o = 2'd2;
                end
                S_MEM_READ: begin
                    memRead_o = 1'b1;
                    iorD_o    = 1'b1;
                end
                S_MEM_WB: begin
                    regWrite_o = 1'b1;
                    memToReg_o = 1'b1;
                end
                S_MEM_WRITE: begin
                    memWrite_o = w_mem_ready;
                    iorD_o     = 1'b1;
                end
                S_R_EXEC: begin
                    aluSrcA_o = 1'b1;
                    case (funct_i)
                        FN_SLL:  aluOp_o = 4'b1000;
                        FN_SRL:  aluOp_o = 4'b1001;
                        FN_SRLV: aluOp_o = 4'b1011;
                        default: aluOp_o = 4'b0010;
                    endcase
                end
                S_R_WB: begin
                    regWrite_o = 1'b1;
                    regDst_o   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA_o     = 1'b1;
                    aluOp_o       = 4'b0001;
                    pcWriteCond_o = 1'b1;
                    pcSource_o    = 2'd1;
                end
                S_JUMP: begin
                    pcWrite_o  = 1'b1;
                    pcSource_o = 2'd2;
                end
                S_I_EXEC: begin
                    aluSrcA_o = 1'b1;
                    aluSrcB_o = 2'd2;
                    case (opcode_i)
                        OP_ADDI: aluOp_o = 4'b0011;
                        OP_ANDI: aluOp_o = 4'b0100;
                        OP_ORI:  aluOp_o = 4'b0101;
                        OP_SLTI: aluOp_o = 4'b0110;
                        OP_XORI: aluOp_o = 4'b0111;
                        default: aluOp_o = 4'b0000;
                    endcase
                end
                S_I_WB: begin
                    regWrite_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state_o = STATE_W'(r_state);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control (MEM_WAIT_EN scenario built when the macro is defined).
`timescale 1ns/1ps
module tb_multi_cycle_control;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [5:0] opcode_i = 6'd0;
    logic [5:0] funct_i  = 6'd0;
    logic       memReady_i = 1'b1;
    logic [3:0] aluOp_o;
    logic       pcWrite_o, pcWriteCond_o, iorD_o, memRead_o, memWrite_o, irWrite_o;
    logic       memToReg_o, regWrite_o, regDst_o, aluSrcA_o, illegal_o;
    logic [1:0] aluSrcB_o, pcSource_o;
    logic [3:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    multi_cycle_control dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct_i(funct_i),
        .memReady_i(memReady_i), .aluOp_o(aluOp_o), .pcWrite_o(pcWrite_o),
        .pcWriteCond_o(pcWriteCond_o), .iorD_o(iorD_o), .memRead_o(memRead_o),
        .memWrite_o(memWrite_o), .irWrite_o(irWrite_o), .memToReg_o(memToReg_o),
        .regWrite_o(regWrite_o), .regDst_o(regDst_o), .aluSrcA_o(aluSrcA_o),
        .aluSrcB_o(aluSrcB_o), .pcSource_o(pcSource_o), .state_o(state_o),
        .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        n_cmp++; if (state_o !== 4'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", state_o); end
        n_cmp++; if ({pcWrite_o, irWrite_o, memRead_o, memWrite_o, regWrite_o, pcWriteCond_o, illegal_o} !== 7'b0) begin
            n_err++; $display("FAIL reset_strobes got=%b exp=0000000",
                {pcWrite_o, irWrite_o, memRead_o, memWrite_o, regWrite_o, pcWriteCond_o, illegal_o});
        end
        rst_i = 1'b0;
        #1;
        n_cmp++; if (memRead_o !== 1'b0 || pcWrite_o !== 1'b0) begin n_err++; $display("FAIL release_quiet memRead=%b pcWrite=%b exp=0,0", memRead_o, pcWrite_o); end
        tick();
        n_cmp++; if (state_o !== 4'd0) begin n_err++; $display("FAIL first_fetch_state got=%0d exp=0", state_o); end
        n_cmp++; if ({memRead_o, irWrite_o, pcWrite_o, aluSrcB_o, aluOp_o} !== {3'b111, 2'd1, 4'b0000}) begin
            n_err++; $display("FAIL first_fetch_outs got=%b%b%b/%0d/%b exp=111/1/0000", memRead_o, irWrite_o, pcWrite_o, aluSrcB_o, aluOp_o);
        end
    endtask

    task automatic test_rtype(input logic [5:0] fn, input logic [3:0] exp_op);
        opcode_i = 6'b000000; funct_i = fn;
        tick();
        n_cmp++; if (state_o !== 4'd1 || aluSrcB_o !== 2'd3) begin n_err++; $display("FAIL r_decode state=%0d srcB=%0d exp=1,3", state_o, aluSrcB_o); end
        tick();
        n_cmp++; if (state_o !== 4'd6) begin n_err++; $display("FAIL r_exec_state got=%0d exp=6", state_o); end
        n_cmp++; if (aluOp_o !== exp_op || aluSrcA_o !== 1'b1 || aluSrcB_o !== 2'd0) begin
            n_err++; $display("FAIL r_exec_alu funct=%b aluOp=%b srcA=%b srcB=%0d exp=%b,1,0", fn, aluOp_o, aluSrcA_o, aluSrcB_o, exp_op);
        end
        tick();
        n_cmp++; if (state_o !== 4'd7 || regWrite_o !== 1'b1 || regDst_o !== 1'b1 || memToReg_o !== 1'b0) begin
            n_err++; $display("FAIL r_wb state=%0d regWrite=%b regDst=%b memToReg=%b exp=7,1,1,0", state_o, regWrite_o, regDst_o, memToReg_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd0 || regWrite_o !== 1'b0) begin n_err++; $display("FAIL r_back_fetch state=%0d regWrite=%b exp=0,0", state_o, regWrite_o); end
    endtask

    task automatic test_lw_sw();
        opcode_i = 6'b100011;
        tick();
        n_cmp++; if (state_o !== 4'd1) begin n_err++; $display("FAIL lw_decode got=%0d exp=1", state_o); end
        tick();
        n_cmp++; if (state_o !== 4'd2 || aluSrcA_o !== 1'b1 || aluSrcB_o !== 2'd2) begin
            n_err++; $display("FAIL lw_addr state=%0d srcA=%b srcB=%0d exp=2,1,2", state_o, aluSrcA_o, aluSrcB_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd3 || memRead_o !== 1'b1 || iorD_o !== 1'b1) begin
            n_err++; $display("FAIL lw_read state=%0d memRead=%b iorD=%b exp=3,1,1", state_o, memRead_o, iorD_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd4 || regWrite_o !== 1'b1 || memToReg_o !== 1'b1 || regDst_o !== 1'b0) begin
            n_err++; $display("FAIL lw_wb state=%0d regWrite=%b memToReg=%b regDst=%b exp=4,1,1,0", state_o, regWrite_o, memToReg_o, regDst_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd0) begin n_err++; $display("FAIL lw_done got=%0d exp=0", state_o); end

        opcode_i = 6'b101011;
        tick();
        tick();
        n_cmp++; if (state_o !== 4'd2) begin n_err++; $display("FAIL sw_addr got=%0d exp=2", state_o); end
        tick();
        n_cmp++; if (state_o !== 4'd5 || memWrite_o !== 1'b1 || iorD_o !== 1'b1 || memRead_o !== 1'b0) begin
            n_err++; $display("FAIL sw_write state=%0d memWrite=%b iorD=%b memRead=%b exp=5,1,1,0", state_o, memWrite_o, iorD_o, memRead_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd0 || memWrite_o !== 1'b0) begin n_err++; $display("FAIL sw_done state=%0d memWrite=%b exp=0,0", state_o, memWrite_o); end
    endtask

    task automatic test_itype();
        logic [5:0] ops [5] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b001110};
        logic [3:0] exp [5] = '{4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
        for (int i = 0; i < 5; i++) begin
            opcode_i = ops[i];
            tick();
            tick();
            n_cmp++; if (state_o !== 4'd10 || aluOp_o !== exp[i] || aluSrcA_o !== 1'b1 || aluSrcB_o !== 2'd2) begin
                n_err++; $display("FAIL i_exec op=%b state=%0d aluOp=%b srcA=%b srcB=%0d exp=10,%b,1,2", ops[i], state_o, aluOp_o, aluSrcA_o, aluSrcB_o, exp[i]);
            end
            tick();
            n_cmp++; if (state_o !== 4'd11 || regWrite_o !== 1'b1 || regDst_o !== 1'b0 || memToReg_o !== 1'b0) begin
                n_err++; $display("FAIL i_wb op=%b state=%0d regWrite=%b regDst=%b memToReg=%b exp=11,1,0,0", ops[i], state_o, regWrite_o, regDst_o, memToReg_o);
            end
            tick();
        end
        n_cmp++; if (state_o !== 4'd0) begin n_err++; $display("FAIL i_done got=%0d exp=0", state_o); end
    endtask

    task automatic test_branch_jump();
        opcode_i = 6'b000100;
        tick();
        tick();
        n_cmp++; if (state_o !== 4'd8 || aluOp_o !== 4'b0001 || pcWriteCond_o !== 1'b1 || pcSource_o !== 2'd1 || pcWrite_o !== 1'b0) begin
            n_err++; $display("FAIL branch state=%0d aluOp=%b cond=%b src=%0d pcWrite=%b exp=8,0001,1,1,0", state_o, aluOp_o, pcWriteCond_o, pcSource_o, pcWrite_o);
        end
        tick();
        opcode_i = 6'b000010;
        tick();
        tick();
        n_cmp++; if (state_o !== 4'd9 || pcWrite_o !== 1'b1 || pcSource_o !== 2'd2) begin
            n_err++; $display("FAIL jump state=%0d pcWrite=%b src=%0d exp=9,1,2", state_o, pcWrite_o, pcSource_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd0) begin n_err++; $display("FAIL jump_done got=%0d exp=0", state_o); end
    endtask

    task automatic test_illegal();
        opcode_i = 6'b111111;
        n_cmp++; if (illegal_o !== 1'b0) begin n_err++; $display("FAIL illegal_in_fetch got=%b exp=0", illegal_o); end
        tick();
        n_cmp++; if (state_o !== 4'd1 || illegal_o !== 1'b1 || regWrite_o !== 1'b0 || memWrite_o !== 1'b0) begin
            n_err++; $display("FAIL illegal_decode state=%0d illegal=%b regWrite=%b memWrite=%b exp=1,1,0,0", state_o, illegal_o, regWrite_o, memWrite_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd0 || illegal_o !== 1'b0 || regWrite_o !== 1'b0 || memWrite_o !== 1'b0) begin
            n_err++; $display("FAIL illegal_after state=%0d illegal=%b regWrite=%b memWrite=%b exp=0,0,0,0", state_o, illegal_o, regWrite_o, memWrite_o);
        end
    endtask

    task automatic test_reset_mid();
        opcode_i = 6'b000000; funct_i = 6'b100000;
        tick(); tick(); tick();
        n_cmp++; if (state_o !== 4'd7 || regWrite_o !== 1'b1) begin n_err++; $display("FAIL mid_pre state=%0d regWrite=%b exp=7,1", state_o, regWrite_o); end
        rst_i = 1'b1;
        #1;
        n_cmp++; if (state_o !== 4'd0 || regWrite_o !== 1'b0) begin n_err++; $display("FAIL mid_reset state=%0d regWrite=%b exp=0,0", state_o, regWrite_o); end
        #2;
        rst_i = 1'b0;
        tick();
        n_cmp++; if (state_o !== 4'd0 || memRead_o !== 1'b1 || irWrite_o !== 1'b1) begin
            n_err++; $display("FAIL mid_restart state=%0d memRead=%b irWrite=%b exp=0,1,1", state_o, memRead_o, irWrite_o);
        end
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        opcode_i = 6'b100011;
        memReady_i = 1'b0;
        #1;
        n_cmp++; if (pcWrite_o !== 1'b0 || irWrite_o !== 1'b0 || memRead_o !== 1'b1) begin
            n_err++; $display("FAIL wait_fetch pcWrite=%b irWrite=%b memRead=%b exp=0,0,1", pcWrite_o, irWrite_o, memRead_o);
        end
        tick();
        n_cmp++; if (state_o !== 4'd0) begin n_err++; $display("FAIL wait_fetch_hold got=%0d exp=0", state_o); end
        memReady_i = 1'b1;
        tick(); tick();
        memReady_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++; if (state_o !== 4'd3 || memRead_o !== 1'b1) begin
                n_err++; $display("FAIL wait_read cycle=%0d state=%0d memRead=%b exp=3,1", c, state_o, memRead_o);
            end
        end
        memReady_i = 1'b1;
        tick();
        n_cmp++; if (state_o !== 4'd4) begin n_err++; $display("FAIL wait_to_wb got=%0d exp=4", state_o); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_rtype(6'b100000, 4'b0010);
        test_rtype(6'b000110, 4'b1011);
        test_rtype(6'b000000, 4'b1000);
        test_rtype(6'b000010, 4'b1001);
        test_lw_sw();
        test_itype();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
